// File: rtl/bullet_controller.sv
// Per-player projectile engine: spawns at the barrel, advances once per frame tick,
// and resolves edge/enemy/wall collisions. Optional wall bounce via `BULLET_BOUNCE_EN.
module bullet_controller #(
  parameter int SPEED         = 4,
  parameter int IMPACT_FRAMES = 8,
  parameter int BULLET_SIZE   = 8,
  parameter int TANK_SIZE     = 32,
  parameter int WALL_H_W      = 64,
  parameter int WALL_H_H      = 32,
  parameter int WALL_V_W      = 32,
  parameter int WALL_V_H      = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [2:0] tank_dir,
  input  logic [9:0] tankX,
  input  logic [9:0] tankY,
  input  logic [9:0] enemyX,
  input  logic [9:0] enemyY,
  input  logic [9:0] wallX1,
  input  logic [9:0] wallY1,
  input  logic [9:0] wallX2,
  input  logic [9:0] wallY2,
  input  logic [9:0] wallX3,
  input  logic [9:0] wallY3,
  input  logic [9:0] wallX4,
  input  logic [9:0] wallY4,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic [1:0] hit,
  output logic       is_bullet,
  output logic       hit_enemy,
  output logic [3:0] hit_count
);

  localparam logic [10:0] SPD      = 11'(SPEED);
  localparam logic [10:0] BSZ      = 11'(BULLET_SIZE);
  localparam logic [10:0] TSZ      = 11'(TANK_SIZE);
  localparam logic [10:0] BARREL   = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] MAX_X    = 11'(639 - BULLET_SIZE);
  localparam logic [10:0] MAX_Y    = 11'(479 - BULLET_SIZE);
  localparam logic [10:0] SCREEN_X = 11'd639;
  localparam logic [10:0] SCREEN_Y = 11'd479;
  localparam logic [10:0] HW       = 11'(WALL_H_W);
  localparam logic [10:0] HH       = 11'(WALL_H_H);
  localparam logic [10:0] VW       = 11'(WALL_V_W);
  localparam logic [10:0] VH       = 11'(WALL_V_H);
  localparam logic [3:0]  LAST_FRAME = 4'(IMPACT_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FLYING = 2'b01,
    S_IMPACT = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    DIR_UP    = 3'b001,
    DIR_RIGHT = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_DOWN  = 3'b100
  } dir_e;

  function automatic logic overlap(input logic [10:0] ax, input logic [10:0] ay,
                                   input logic [10:0] aw, input logic [10:0] ah,
                                   input logic [10:0] bx, input logic [10:0] by,
                                   input logic [10:0] bw, input logic [10:0] bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  // Frame-tick synchroniser and fire edge detect
  logic f_sync1, f_sync2, f_dly, tick;
  logic fire_q1, fire_q2;
  logic fire_edge;

  assign fire_edge = fire_q1 & ~fire_q2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      f_sync1 <= 1'b0;
      f_sync2 <= 1'b0;
      f_dly   <= 1'b0;
      tick    <= 1'b0;
      fire_q1 <= 1'b0;
      fire_q2 <= 1'b0;
    end else begin
      f_sync1 <= frame_clk;
      f_sync2 <= f_sync1;
      f_dly   <= f_sync2;
      tick    <= f_sync2 & ~f_dly;
      fire_q1 <= fire;
      fire_q2 <= fire_q1;
    end
  end

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hits_q, hits_d;
  logic       hit_enemy_q, hit_enemy_d;
  logic       fire_pend_q, fire_pend_d;
`ifdef BULLET_BOUNCE_EN
  logic       bounced_q, bounced_d;
`endif

  // Spawn point at the barrel for the current facing
  logic [10:0] tx, ty, spawn_x, spawn_y;
  logic        spawn_ok;
  dir_e        spawn_dir;

  assign tx = {1'b0, tankX};
  assign ty = {1'b0, tankY};

  // NOTE: every combinational output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    spawn_x   = tx;
    spawn_y   = ty;
    spawn_ok  = 1'b1;
    spawn_dir = DIR_UP;
    case (tank_dir)
      3'b001: begin
        spawn_dir = DIR_UP;
        spawn_x   = tx + BARREL;
        spawn_ok  = (ty >= BSZ);
        spawn_y   = ty - BSZ;
      end
      3'b100: begin
        spawn_dir = DIR_DOWN;
        spawn_x   = tx + BARREL;
        spawn_y   = ty + TSZ;
      end
      3'b010: begin
        spawn_dir = DIR_RIGHT;
        spawn_x   = tx + TSZ;
        spawn_y   = ty + BARREL;
      end
      3'b011: begin
        spawn_dir = DIR_LEFT;
        spawn_ok  = (tx >= BSZ);
        spawn_x   = tx - BSZ;
        spawn_y   = ty + BARREL;
      end
      default: spawn_ok = 1'b0;
    endcase
    if (spawn_x > SCREEN_X || spawn_y > SCREEN_Y) spawn_ok = 1'b0;
  end

  // Candidate next position and collision tests against it
  logic [10:0] nx, ny;
  logic        underflow, off_edge, enemy_hit, wall_hit;

  always_comb begin
    nx        = {1'b0, x_q};
    ny        = {1'b0, y_q};
    underflow = 1'b0;
    case (dir_q)
      DIR_UP: begin
        underflow = (ny < SPD);
        ny        = ny - SPD;
      end
      DIR_DOWN:  ny = ny + SPD;
      DIR_RIGHT: nx = nx + SPD;
      DIR_LEFT: begin
        underflow = (nx < SPD);
        nx        = nx - SPD;
      end
      default: underflow = 1'b1;
    endcase
    off_edge  = underflow || (nx > MAX_X) || (ny > MAX_Y);
    enemy_hit = overlap(nx, ny, BSZ, BSZ, {1'b0, enemyX}, {1'b0, enemyY}, TSZ, TSZ);
    wall_hit  = overlap(nx, ny, BSZ, BSZ, {1'b0, wallX1}, {1'b0, wallY1}, HW, HH)
              | overlap(nx, ny, BSZ, BSZ, {1'b0, wallX2}, {1'b0, wallY2}, VW, VH)
              | overlap(nx, ny, BSZ, BSZ, {1'b0, wallX3}, {1'b0, wallY3}, HW, HH)
              | overlap(nx, ny, BSZ, BSZ, {1'b0, wallX4}, {1'b0, wallY4}, VW, VH);
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    hits_d      = hits_q;
    hit_enemy_d = 1'b0;
`ifdef BULLET_BOUNCE_EN
    bounced_d   = bounced_q;
`endif
    // Shots never queue: the request only survives while idle
    if (state_q != S_IDLE) fire_pend_d = 1'b0;
    else if (fire_edge)    fire_pend_d = 1'b1;
    else if (tick)         fire_pend_d = 1'b0;
    else                   fire_pend_d = fire_pend_q;

    case (state_q)
      S_IDLE: begin
        if (tick && fire_pend_q && spawn_ok) begin
          state_d = S_FLYING;
          dir_d   = spawn_dir;
          x_d     = spawn_x[9:0];
          y_d     = spawn_y[9:0];
`ifdef BULLET_BOUNCE_EN
          bounced_d = 1'b0;
`endif
        end
      end
      S_FLYING: begin
        if (tick) begin
          if (off_edge) begin
            state_d = S_IDLE;
          end else begin
            x_d = nx[9:0];
            y_d = ny[9:0];
            if (enemy_hit) begin
              state_d     = S_IMPACT;
              cnt_d       = 4'd0;
              hit_enemy_d = 1'b1;
              hits_d      = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;
            end else if (wall_hit) begin
`ifdef BULLET_BOUNCE_EN
              if (!bounced_q) begin
                x_d       = x_q;
                y_d       = y_q;
                bounced_d = 1'b1;
                case (dir_q)
                  DIR_UP:    dir_d = DIR_DOWN;
                  DIR_DOWN:  dir_d = DIR_UP;
                  DIR_LEFT:  dir_d = DIR_RIGHT;
                  default:   dir_d = DIR_LEFT;
                endcase
              end else begin
                state_d = S_IMPACT;
                cnt_d   = 4'd0;
              end
`else
              state_d = S_IMPACT;
              cnt_d   = 4'd0;
`endif
            end
          end
        end
      end
      S_IMPACT: begin
        if (tick) begin
          if (cnt_q == LAST_FRAME) state_d = S_IDLE;
          else                     cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_UP;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      cnt_q       <= 4'd0;
      hits_q      <= 4'd0;
      hit_enemy_q <= 1'b0;
      fire_pend_q <= 1'b0;
`ifdef BULLET_BOUNCE_EN
      bounced_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      hits_q      <= hits_d;
      hit_enemy_q <= hit_enemy_d;
      fire_pend_q <= fire_pend_d;
`ifdef BULLET_BOUNCE_EN
      bounced_q   <= bounced_d;
`endif
    end
  end

  assign bulletX   = x_q;
  assign bulletY   = y_q;
  assign hit       = state_q;
  assign hit_enemy = hit_enemy_q;
  assign hit_count = hits_q;

  // Zero-latency pixel test so the colour mapper can address the sprite same cycle
  assign is_bullet = (state_q != S_IDLE)
                   && ({1'b0, DrawX} >= {1'b0, x_q}) && ({1'b0, DrawX} < {1'b0, x_q} + BSZ)
                   && ({1'b0, DrawY} >= {1'b0, y_q}) && ({1'b0, DrawY} < {1'b0, y_q} + BSZ);

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: per-tick expectations go through a scoreboard
// queue and are checked with immediate assertions after each frame tick.
module tb_bullet_controller;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, fire;
  logic [2:0] tank_dir;
  logic [9:0] tankX, tankY, enemyX, enemyY;
  logic [9:0] wallX1, wallY1, wallX2, wallY2, wallX3, wallY3, wallX4, wallY4;
  logic [9:0] DrawX, DrawY;
  logic [9:0] bulletX, bulletY;
  logic [1:0] hit;
  logic       is_bullet, hit_enemy;
  logic [3:0] hit_count;

  bullet_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire), .tank_dir(tank_dir),
    .tankX(tankX), .tankY(tankY), .enemyX(enemyX), .enemyY(enemyY),
    .wallX1(wallX1), .wallY1(wallY1), .wallX2(wallX2), .wallY2(wallY2),
    .wallX3(wallX3), .wallY3(wallY3), .wallX4(wallX4), .wallY4(wallY4),
    .DrawX(DrawX), .DrawY(DrawY), .bulletX(bulletX), .bulletY(bulletY),
    .hit(hit), .is_bullet(is_bullet), .hit_enemy(hit_enemy), .hit_count(hit_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    logic [1:0] hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] hc;
    int         pulses;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame_clk pulse; counts hit_enemy cycles seen during the tick window
  task automatic frame_tick(output int pulses);
    pulses = 0;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (hit_enemy === 1'b1) pulses++;
    end
    frame_clk = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (hit_enemy === 1'b1) pulses++;
    end
  endtask

  task automatic tick_expect(input string tag, input logic [1:0] h, input int x, input int y,
                             input int hc, input int pl);
    exp_t e;
    int   p;
    e.tag = tag; e.hit = h; e.x = 10'(x); e.y = 10'(y); e.hc = 4'(hc); e.pulses = pl;
    sb.push_back(e);
    frame_tick(p);
    e = sb.pop_front();
    check({e.tag, ".hit"}, 32'(hit), 32'(e.hit));
    check({e.tag, ".x"}, 32'(bulletX), 32'(e.x));
    check({e.tag, ".y"}, 32'(bulletY), 32'(e.y));
    check({e.tag, ".hit_count"}, 32'(hit_count), 32'(e.hc));
    check({e.tag, ".pulses"}, 32'(p), 32'(e.pulses));
  endtask

  task automatic pulse_fire();
    @(negedge Clk) fire = 1'b1;
    repeat (2) @(negedge Clk);
    fire = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int cnt;
    int p;
    int imp_x;
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; tank_dir = 3'b010;
    tankX = 10'd100; tankY = 10'd200; enemyX = 10'd600; enemyY = 10'd0;
    wallX1 = 10'd0;   wallY1 = 10'd440; wallX2 = 10'd100; wallY2 = 10'd400;
    wallX3 = 10'd300; wallY3 = 10'd440; wallX4 = 10'd500; wallY4 = 10'd400;
    DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Reset state
    check("rst.hit", 32'(hit), 32'd0);
    check("rst.x", 32'(bulletX), 32'd0);
    check("rst.y", 32'(bulletY), 32'd0);
    check("rst.is_bullet", 32'(is_bullet), 32'd0);
    check("rst.hit_enemy", 32'(hit_enemy), 32'd0);
    check("rst.hit_count", 32'(hit_count), 32'd0);

    // Spawn facing right and fly three frames
    pulse_fire();
    tick_expect("spawn_r", 2'b01, 132, 212, 0, 0);
    tick_expect("fly1", 2'b01, 136, 212, 0, 0);
    tick_expect("fly2", 2'b01, 140, 212, 0, 0);
    tick_expect("fly3", 2'b01, 144, 212, 0, 0);

    // Pixel sweep around the 8x8 box at (144,212)
    cnt = 0;
    for (int j = 204; j < 228; j++) begin
      for (int i = 136; i < 160; i++) begin
        DrawX = 10'(i); DrawY = 10'(j);
        #1;
        if (is_bullet === 1'b1) cnt++;
      end
    end
    check("sweep.count", 32'(cnt), 32'd64);
    DrawX = 10'd152; DrawY = 10'd212; #1;
    check("sweep.right_edge_out", 32'(is_bullet), 32'd0);
    DrawX = 10'd151; DrawY = 10'd219; #1;
    check("sweep.corner_in", 32'(is_bullet), 32'd1);
    DrawX = 10'd144; DrawY = 10'd211; #1;
    check("sweep.top_edge_out", 32'(is_bullet), 32'd0);

    // Fire while flying is ignored; fly to the right screen edge
    pulse_fire();
    tick_expect("fire_in_flight", 2'b01, 148, 212, 0, 0);
    repeat (120) frame_tick(p);
    check("edge_pre.hit", 32'(hit), 32'd1);
    check("edge_pre.x", 32'(bulletX), 32'd628);
    tick_expect("edge_exit", 2'b00, 628, 212, 0, 0);
    tick_expect("no_requeue", 2'b00, 628, 212, 0, 0);

    // Spawn underflow and invalid direction drop the request
    tank_dir = 3'b001; tankY = 10'd4;
    pulse_fire();
    tick_expect("spawn_uf", 2'b00, 628, 212, 0, 0);
    tank_dir = 3'b111; tankY = 10'd200;
    pulse_fire();
    tick_expect("bad_dir", 2'b00, 628, 212, 0, 0);

    // Enemy hit: overlap first occurs at X=196 (196+8 > 200)
    tank_dir = 3'b010; enemyX = 10'd200; enemyY = 10'd200;
    pulse_fire();
    tick_expect("spawn_e", 2'b01, 132, 212, 0, 0);
    tank_dir = 3'b001;
    for (int k = 1; k <= 16; k++)
      tick_expect($sformatf("enemy_fly%0d", k), (k == 16) ? 2'b10 : 2'b01, 132 + 4 * k, 212,
                  (k == 16) ? 1 : 0, (k == 16) ? 1 : 0);
    for (int k = 1; k <= 8; k++)
      tick_expect($sformatf("impact%0d", k), (k == 8) ? 2'b00 : 2'b10, 196, 212, 1, 0);

    // Wall collision
    tank_dir = 3'b010; enemyX = 10'd600; enemyY = 10'd0;
    wallX1 = 10'd180; wallY1 = 10'd200; wallX3 = 10'd40; wallY3 = 10'd200;
    pulse_fire();
    tick_expect("spawn_w", 2'b01, 132, 212, 1, 0);
    for (int k = 1; k <= 10; k++)
      tick_expect($sformatf("wall_fly%0d", k), 2'b01, 132 + 4 * k, 212, 1, 0);
`ifdef BULLET_BOUNCE_EN
    tick_expect("bounce", 2'b01, 172, 212, 1, 0);
    for (int k = 1; k <= 18; k++)
      tick_expect($sformatf("bounce_fly%0d", k), (k == 18) ? 2'b10 : 2'b01, 172 - 4 * k, 212, 1, 0);
    imp_x = 100;
`else
    tick_expect("wall_impact", 2'b10, 176, 212, 1, 0);
    imp_x = 176;
`endif
    tick_expect("wall_hold1", 2'b10, imp_x, 212, 1, 0);
    tick_expect("wall_hold2", 2'b10, imp_x, 212, 1, 0);

    // Reset during impact
    DrawX = 10'(imp_x + 3); DrawY = 10'd215; #1;
    check("pre_rst.is_bullet", 32'(is_bullet), 32'd1);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst.hit", 32'(hit), 32'd0);
    check("mid_rst.is_bullet", 32'(is_bullet), 32'd0);
    check("mid_rst.hit_count", 32'(hit_count), 32'd0);
    check("mid_rst.x", 32'(bulletX), 32'd0);
    Reset = 1'b0;
    tick_expect("post_rst", 2'b00, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
